// File: rtl/fmdll_div_ctrl.sv
// rtl/fmdll_div_ctrl.sv - FMDLL feedback divide-by-N sequencer with glitch-free N reprogramming
module fmdll_div_ctrl #(
    parameter int NW             = 4,
    parameter int DEFAULT_N      = 8,
    parameter int SETTLE_PERIODS = 4
) (
    input  logic          clk_out,
    input  logic          rst_n,
    input  logic          en,
    input  logic          n_req_valid,
    input  logic [NW-1:0] n_req_val,
    output logic          n_req_ready,
    output logic [NW-1:0] n_active,
    output logic [NW-1:0] n_counter,
    output logic          div_n,
    output logic          period_start,
    output logic          pd_enable,
    output logic          settling,
    output logic          cfg_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RUN    = 2'd2
    } state_t;

    localparam logic [NW-1:0] DEF_N       = NW'(DEFAULT_N);
    localparam logic [NW-1:0] ONE_N       = NW'(1);
    localparam logic [NW-1:0] MIN_N       = NW'(2);
    localparam logic [3:0]    SETTLE_INIT = 4'(SETTLE_PERIODS);

    state_t        state_q, state_d;
    logic [NW-1:0] n_active_q, n_active_d;
    logic [NW-1:0] cnt_q, cnt_d;
    logic [NW-1:0] pending_n_q, pending_n_d;
    logic          pending_q, pending_d;
    logic          div_n_q, div_n_d;
    logic          cfg_err_q, cfg_err_d;
    logic [3:0]    settle_cnt_q, settle_cnt_d;
    logic          wrap;

    assign wrap = (state_q != IDLE) && (cnt_q == n_active_q - ONE_N);

    always_comb begin
        state_d      = state_q;
        n_active_d   = n_active_q;
        cnt_d        = cnt_q;
        pending_n_d  = pending_n_q;
        pending_d    = pending_q;
        settle_cnt_d = settle_cnt_q;
        div_n_d      = 1'b1;
        cfg_err_d    = 1'b0;

        if (!en) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d      = SETTLE;
                    cnt_d        = '0;
                    settle_cnt_d = SETTLE_INIT;
                end
                default: begin
                    cnt_d   = wrap ? '0 : cnt_q + ONE_N;
                    div_n_d = !wrap;
                    if (wrap) begin
                        if (pending_q) begin
                            state_d      = SETTLE;
                            settle_cnt_d = SETTLE_INIT;
                        end else if (state_q == SETTLE) begin
                            if (settle_cnt_q == 4'd1) begin
                                state_d = RUN;
                            end else begin
                                settle_cnt_d = settle_cnt_q - 4'd1;
                            end
                        end
                    end
                end
            endcase
        end

        // A new N only lands on a period boundary, or any time the divider is stopped.
        if (pending_q && ((state_q == IDLE) || (wrap && en))) begin
            n_active_d = pending_n_q;
            pending_d  = 1'b0;
        end

        if (n_req_valid && !pending_q) begin
            if (n_req_val < MIN_N) begin
                cfg_err_d = 1'b1;
            end else begin
                pending_d   = 1'b1;
                pending_n_d = n_req_val;
            end
        end
    end

    always_ff @(posedge clk_out or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            n_active_q   <= DEF_N;
            cnt_q        <= '0;
            pending_n_q  <= '0;
            pending_q    <= 1'b0;
            div_n_q      <= 1'b1;
            cfg_err_q    <= 1'b0;
            settle_cnt_q <= SETTLE_INIT;
        end else begin
            state_q      <= state_d;
            n_active_q   <= n_active_d;
            cnt_q        <= cnt_d;
            pending_n_q  <= pending_n_d;
            pending_q    <= pending_d;
            div_n_q      <= div_n_d;
            cfg_err_q    <= cfg_err_d;
            settle_cnt_q <= settle_cnt_d;
        end
    end

    assign n_req_ready  = !pending_q;
    assign n_active     = n_active_q;
    assign n_counter    = cnt_q;
    assign div_n        = div_n_q;
    assign period_start = (state_q != IDLE) && (cnt_q == '0);
    assign pd_enable    = (state_q == RUN);
    assign settling     = (state_q == SETTLE);
    assign cfg_err      = cfg_err_q;

endmodule

// File: doc/fmdll_div_ctrl.md
Name: fmdll_div_ctrl

Overview:
Sequencer for the FMDLL feedback divide-by-N path. It generates the wrapping N_counter that the divide-by-N stage decodes, and mirrors the DIV_N pulse. It owns the active N value and accepts reprogramming requests through a valid/ready handshake, applying each one only at a period boundary so the feedback clock never glitches. After every start or N change it blanks the phase detector for a fixed number of settle periods.

Parameters:
NW, 4, width of N and of the counter
DEFAULT_N, 8, active N after reset (must be in 2..2^NW-1)
SETTLE_PERIODS, 4, number of full divider periods that pd_enable stays low after start or N change (range 1..15)

Ports:
clk_out  in  1  DLL output clock; all logic on its rising edge
rst_n  in  1  reset; asynchronous, active-low
en  in  1  divider run enable
n_req_valid  in  1  new-N request valid
n_req_val  in  NW  requested N
n_req_ready  out  1  request may be accepted
n_active  out  NW  N currently in use
n_counter  out  NW  divider phase count, 0..n_active-1
div_n  out  1  feedback divider output, low one cycle per period
period_start  out  1  one-cycle pulse when n_counter==0 in RUN/SETTLE
pd_enable  out  1  phase-detector enable
settling  out  1  high while state==SETTLE
cfg_err  out  1  one-cycle pulse when a request is illegal

Behaviour:
- Reset (async, rst_n=0) values:
  - state=IDLE; n_active=DEFAULT_N; n_counter=0; div_n=1.
  - period_start=0; pd_enable=0; settling=0; cfg_err=0.
  - pending=0, so n_req_ready=1.
- States:
  - IDLE to SETTLE when en=1.
  - SETTLE to RUN after SETTLE_PERIODS wraps.
  - Any state to IDLE when en=0, taking effect the next cycle.
- Counter, registered:
  - In IDLE, held at 0.
  - Otherwise increments each cycle and wraps to 0 after n_active-1. This wrap cycle is called "wrap".
- div_n, registered:
  - Equals 0 in the cycle after n_counter==n_active-1, i.e. it is low coincident with n_counter==0.
  - Equals 1 at all other times, including IDLE.
- period_start: combinational, (state!=IDLE) && n_counter==0.
- Handshake:
  - n_req_ready = !pending.
  - Transfer occurs when n_req_valid && n_req_ready.
  - Illegal value (n_req_val<2): accepted but discarded; cfg_err=1 in the next cycle only; no pending set; n_active unchanged.
  - Legal value: latched into pending_n; pending=1; ready drops from the next cycle.
- Apply rules:
  - In RUN/SETTLE, pending applies at the next wrap. n_counter goes to 0 and n_active=pending_n in the same cycle; pending clears; FSM enters SETTLE with settle_cnt=SETTLE_PERIODS.
  - A request accepted in the wrap cycle itself is not applied at that wrap; it waits for the following wrap.
  - In IDLE, pending applies the cycle after acceptance.
  - If en falls while pending=1, pending applies on the first IDLE cycle.
- SETTLE:
  - On entry: pd_enable=0 and settle_cnt=SETTLE_PERIODS.
  - Each wrap decrements settle_cnt.
  - The wrap with settle_cnt==1 moves to RUN, with pd_enable=1 from the next cycle (n_counter==0).
  - pd_enable therefore rises exactly SETTLE_PERIODS*n_active cycles after SETTLE entry.
  - A new N applied during SETTLE restarts the count.
- RUN: pd_enable=1; the state is held until en=0 or an N change is applied.
- en=0: next cycle state=IDLE, n_counter=0, div_n=1, pd_enable=0, settling=0.
- Simultaneous events:
  - en=0 and wrap in the same cycle: IDLE wins.
  - Request and en rise in the same cycle: SETTLE starts with the old N; the new N applies at the first wrap and restarts settle.
- Widths: all compares are NW bits unsigned; the counter never exceeds n_active-1.

Test Plan:
- Reset, DEFAULT_N=8, en=1 at t0:
  - n_counter runs 0..7 repeating; div_n low on every n_counter==0 cycle (every 8 cycles).
  - settling=1, then pd_enable rises 32 cycles after SETTLE entry.
- RUN with N=8, request N=5 at n_counter=3:
  - ready low from the next cycle.
  - Counter sequence ...7,0,1,2,3,4,0 with n_active=5 at the wrap.
  - pd_enable low for 20 cycles, then high; ready high again.
- Request N=1 in RUN:
  - accepted; cfg_err=1 for one cycle; n_active stays 8; counter period unchanged.
- Request N=6 asserted exactly when n_counter==7 (N=8):
  - next period still uses N=8; n_active=6 after the subsequent wrap.
- en dropped at n_counter=4 with a request pending:
  - next cycle IDLE, counter 0, div_n=1, pd_enable=0.
  - Pending N is applied in IDLE; en=1 again restarts SETTLE with the new N.
- rst_n pulsed low mid-SETTLE:
  - all outputs return to their reset values immediately.
  - After release with en=1, settle counting starts fresh from SETTLE_PERIODS.
